// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared IF/MEM memory port: grant, port handshake, one response register.
// Optional IF starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic          mem_req,
   input  logic          mem_we,
   input  logic          port_ack,
   input  logic [DW-1:0] port_rdata,
   output logic          port_sel,
   output logic          port_valid,
   output logic          port_we,
   output logic          if_ready,
   output logic          mem_ready,
   output logic [DW-1:0] rsp_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t state;
   logic   if_first;
   logic   grant_mem;

   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("mem_port_arbiter: MAX_WAIT must be in 1..15");
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [3:0] wait_cnt;

   // IF overrides MEM priority once MEM has won MAX_WAIT arbitrations in a row against it
   assign if_first = if_req && (wait_cnt == 4'(MAX_WAIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state == IDLE && (mem_req || if_req)) begin
         if (grant_mem && if_req)
            wait_cnt <= wait_cnt + 4'd1;
         else
            wait_cnt <= '0;
      end
   end
`else
   assign if_first = 1'b0;
`endif

   assign grant_mem = mem_req && !if_first;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         port_sel   <= 1'b0;
         port_valid <= 1'b0;
         port_we    <= 1'b0;
         if_ready   <= 1'b0;
         mem_ready  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         if_ready  <= 1'b0;
         mem_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_req || if_req) begin
                  state      <= ISSUE;
                  port_sel   <= grant_mem;
                  port_valid <= 1'b1;
                  port_we    <= grant_mem && mem_we;
               end
            end
            ISSUE: begin
               if (port_ack) begin
                  state      <= RESP;
                  rsp_rdata  <= port_rdata;
                  port_valid <= 1'b0;
                  port_we    <= 1'b0;
                  if_ready   <= !port_sel;
                  mem_ready  <= port_sel;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

   localparam int DW       = 32;
   localparam int MAX_WAIT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          if_req = 1'b0;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic          port_ack;
   logic [DW-1:0] port_rdata;
   logic          port_sel, port_valid, port_we, if_ready, mem_ready;
   logic [DW-1:0] rsp_rdata;

   logic          auto_ack = 1'b0;
   logic          man_ack = 1'b0;
   logic [DW-1:0] man_rdata = '0;

   int total = 0;
   int bad   = 0;

   // zero-wait memory in auto mode, otherwise acks driven by the scenario
   assign port_ack   = auto_ack ? port_valid : man_ack;
   assign port_rdata = man_rdata;

   mem_port_arbiter #(.DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .if_req(if_req), .mem_req(mem_req), .mem_we(mem_we),
      .port_ack(port_ack), .port_rdata(port_rdata), .port_sel(port_sel),
      .port_valid(port_valid), .port_we(port_we), .if_ready(if_ready),
      .mem_ready(mem_ready), .rsp_rdata(rsp_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // Model: one transaction record (who owns the port, whether the memory has answered)
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   bit            t_open, t_answered, t_is_mem, t_write;
   logic [DW-1:0] t_data;
   int            mem_streak;

   function automatic bit if_wins(input bit ir, input bit mr, input int streak);
      return !mr || (GUARD && ir && streak == MAX_WAIT);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_open <= 0; t_answered <= 0; t_is_mem <= 0; t_write <= 0;
         t_data <= '0; mem_streak <= 0;
      end else if (!t_open) begin
         if (if_req || mem_req) begin
            t_open     <= 1;
            t_answered <= 0;
            t_is_mem   <= !if_wins(if_req, mem_req, mem_streak);
            t_write    <= !if_wins(if_req, mem_req, mem_streak) && mem_we;
            mem_streak <= (!if_wins(if_req, mem_req, mem_streak) && if_req) ? mem_streak + 1 : 0;
         end
      end else if (!t_answered) begin
         if (port_ack) begin
            t_answered <= 1;
            t_data     <= port_rdata;
         end
      end else begin
         t_open <= 0;
      end
   end

   bit  prev_valid = 0;
   bit  grants[$];

   always @(negedge clk) begin
      chk("port_valid", port_valid, t_open && !t_answered);
      chk("port_we",    port_we,    t_open && !t_answered && t_write);
      chk("port_sel",   port_sel,   t_is_mem);
      chk("if_ready",   if_ready,   t_open && t_answered && !t_is_mem);
      chk("mem_ready",  mem_ready,  t_open && t_answered && t_is_mem);
      chk("rsp_rdata",  rsp_rdata,  t_data);
      if (port_valid && !prev_valid) grants.push_back(port_sel);
      prev_valid = port_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset port_valid", port_valid, 0);
      chk("reset rsp_rdata", rsp_rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single IF read, ack in first ISSUE cycle
      if_req = 1; man_rdata = 32'h8C010004;
      @(negedge clk);
      chk("t1 valid c1", port_valid, 1);
      chk("t1 sel c1", port_sel, 0);
      man_ack = 1;
      @(negedge clk);
      chk("t1 if_ready c2", if_ready, 1);
      chk("t1 valid c2", port_valid, 0);
      chk("t1 rsp c2", rsp_rdata, 32'h8C010004);
      man_ack = 0; if_req = 0;
      @(negedge clk);
      chk("t1 if_ready c3", if_ready, 0);

      // MEM write, ack after 3 wait cycles
      mem_req = 1; mem_we = 1; man_rdata = 32'hDEAD0001;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk("t2 valid", port_valid, 1);
         chk("t2 we", port_we, 1);
         chk("t2 mem_ready early", mem_ready, 0);
      end
      man_ack = 1;
      @(negedge clk);
      chk("t2 mem_ready c5", mem_ready, 1);
      chk("t2 if_ready c5", if_ready, 0);
      chk("t2 we c5", port_we, 0);
      man_ack = 0; mem_req = 0; mem_we = 0;
      @(negedge clk);

      // simultaneous requests: MEM first, then IF
      auto_ack = 1; man_rdata = 32'h0BAD_F00D;
      mem_req = 1; if_req = 1;
      @(negedge clk);
      chk("t3 sel c1", port_sel, 1);
      @(negedge clk);
      chk("t3 mem_ready c2", mem_ready, 1);
      mem_req = 0;
      @(negedge clk);
      chk("t3 valid c3", port_valid, 0);
      @(negedge clk);
      chk("t3 valid c4", port_valid, 1);
      chk("t3 sel c4", port_sel, 0);
      @(negedge clk);
      chk("t3 if_ready c5", if_ready, 1);
      if_req = 0;
      @(negedge clk);

      // both requests held, zero-wait memory
      grants.delete();
      mem_req = 1; if_req = 1;
      repeat (31) @(negedge clk);
      mem_req = 0; if_req = 0;
      repeat (4) @(negedge clk);
      chk("t4 grant count>=10", grants.size() >= 10, 1);
      for (int i = 0; i < 10 && i < grants.size(); i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
         chk("t4 grant pattern", grants[i], (i % 5 == 4) ? 0 : 1);
`else
         chk("t4 grant pattern", grants[i], 1);
`endif
      end
      auto_ack = 0;

      // async reset mid-ISSUE, late ack ignored, then normal IF read
      if_req = 1;
      @(negedge clk);
      chk("t5 valid before reset", port_valid, 1);
      #1 rst_n = 0;
      #1;
      chk("t5 rst valid", port_valid, 0);
      chk("t5 rst sel", port_sel, 0);
      chk("t5 rst we", port_we, 0);
      chk("t5 rst readys", {if_ready, mem_ready}, 0);
      chk("t5 rst rsp", rsp_rdata, 0);
      if_req = 0;
      @(negedge clk);
      rst_n = 1; man_ack = 1;
      @(negedge clk);
      chk("t5 late ack readys", {if_ready, mem_ready}, 0);
      chk("t5 late ack valid", port_valid, 0);
      man_ack = 0;
      @(negedge clk);
      if_req = 1; man_rdata = 32'h12345678;
      @(negedge clk);
      chk("t5 valid c1", port_valid, 1);
      @(negedge clk);
      man_ack = 1;
      @(negedge clk);
      chk("t5 if_ready c3", if_ready, 1);
      chk("t5 rsp c3", rsp_rdata, 32'h12345678);
      man_ack = 0; if_req = 0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
